us_frame_seq: RTL

- Frame sequencer directly upstream of the ultrasonic channel block; generates its control strobes and sequences its handshake.
- Per frame it pulses o_sync, then for each enabled sub-channel:
  - loads parameters and waits for parameter-done;
  - fires a sub-sync and waits for acquisition done.
- It then flips the write half of the ping-pong data buffer and reports frame completion. Each wait is timeout-guarded so a stuck channel cannot hang the frame.

---
 rtl/us_seq_pkg.sv | 19 +
 rtl/us_seq_prio.sv | 23 ++
 rtl/us_frame_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/us_seq_pkg.sv
// Shared constants and the state encoding for the ultrasonic frame sequencer.
package us_seq_pkg;

    localparam int          CH_NUM           = 8;
    localparam int          CH_W             = 3;
    localparam logic [15:0] TMO_CYCLES_DFLT  = 16'd50000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        LOAD   = 3'd2,
        PWAIT  = 3'd3,
        FIRE   = 3'd4,
        DWAIT  = 3'd5,
        NEXT   = 3'd6,
        FINISH = 3'd7
    } state_t;

endpackage

// File: rtl/us_seq_prio.sv
// Lowest-set-bit encoder: picks the next pending sub-channel in ascending order.
// Purely combinational; vld is low when no bit is set.
module us_seq_prio
    import us_seq_pkg::*;
(
    input  logic [CH_NUM-1:0] mask,
    output logic [CH_W-1:0]   idx,
    output logic              vld
);

    // Scanning downwards lets the lowest set bit win.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CH_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/us_frame_seq.sv
// Frame sequencer ahead of the ultrasonic channel block: sync, per-channel load/fire
// handshakes with timeout guards, ping-pong half flip. All outputs are registered.
module us_frame_seq
    import us_seq_pkg::*;
#(
    parameter int               TMO_W      = 16,
    parameter logic [TMO_W-1:0] TMO_CYCLES = TMO_W'(TMO_CYCLES_DFLT)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [CH_NUM-1:0] i_ch_mask,
    output logic              o_sync,
    output logic              o_load_param,
    output logic [CH_W-1:0]   o_sub_channel,
    input  logic              i_param_done,
    output logic              o_sub_sync,
    input  logic              i_done,
    output logic              o_wr_half,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_timeout,
    output logic              o_overrun
);

    state_t             state, state_nxt;
    logic [CH_NUM-1:0]  pend_mask, pend_nxt, pend_clr, cur_bit, prio_in;
    logic [TMO_W-1:0]   tmo_cnt, cnt_nxt;
    logic [CH_W-1:0]    ch_nxt, prio_idx;
    logic               prio_vld, tmo_nxt, wr_nxt, tmo_hit, past_guard;

    always_comb begin
        cur_bit                = '0;
        cur_bit[o_sub_channel] = 1'b1;
        pend_clr               = pend_mask & ~cur_bit;
        prio_in                = (state == NEXT) ? pend_clr : pend_mask;
    end

    us_seq_prio u_prio (
        .mask (prio_in),
        .idx  (prio_idx),
        .vld  (prio_vld)
    );

    // The counter is zero only in the first cycle of a wait, which doubles as the guard.
    assign tmo_hit    = (tmo_cnt == TMO_CYCLES - 1'b1);
    assign past_guard = (tmo_cnt != '0);

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_mask;
        ch_nxt    = o_sub_channel;
        cnt_nxt   = tmo_cnt;
        tmo_nxt   = o_timeout;
        wr_nxt    = o_wr_half;
        case (state)
            IDLE: begin
                if (i_start) begin
                    pend_nxt  = i_ch_mask;
                    tmo_nxt   = 1'b0;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                if (prio_vld) begin
                    ch_nxt    = prio_idx;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = FINISH;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = PWAIT;
            end
            PWAIT: begin
                if (past_guard && i_param_done) begin
                    state_nxt = FIRE;
                end else if (tmo_hit) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = NEXT;
                end else if (tmo_cnt != '1) begin
                    cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            FIRE: begin
                cnt_nxt   = '0;
                state_nxt = DWAIT;
            end
            DWAIT: begin
                if (past_guard && i_done) begin
                    state_nxt = NEXT;
                end else if (tmo_hit) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = NEXT;
                end else if (tmo_cnt != '1) begin
                    cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            NEXT: begin
                pend_nxt = pend_clr;
                if (prio_vld) begin
                    ch_nxt    = prio_idx;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                wr_nxt    = ~o_wr_half;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are aligned with the state they belong to; frame_done follows FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend_mask     <= '0;
            tmo_cnt       <= '0;
            o_sub_channel <= '0;
            o_timeout     <= 1'b0;
            o_wr_half     <= 1'b0;
            o_sync        <= 1'b0;
            o_load_param  <= 1'b0;
            o_sub_sync    <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            state         <= state_nxt;
            pend_mask     <= pend_nxt;
            tmo_cnt       <= cnt_nxt;
            o_sub_channel <= ch_nxt;
            o_timeout     <= tmo_nxt;
            o_wr_half     <= wr_nxt;
            o_sync        <= (state_nxt == SYNC);
            o_load_param  <= (state_nxt == LOAD);
            o_sub_sync    <= (state_nxt == FIRE);
            o_busy        <= (state_nxt != IDLE);
            o_frame_done  <= (state == FINISH);
            o_overrun     <= i_start && (state != IDLE);
        end
    end

endmodule
